// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: S-box, word helpers and key-size derivations.
package aes_pkg;

  typedef enum logic [1:0] {AES128, AES192, AES256} key_size_e;

  // Entry 0 is the leftmost byte so SBOX[x] indexes naturally.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic key_size_e key_size_of(int unsigned key_bits);
    case (key_bits)
      192:     return AES192;
      256:     return AES256;
      default: return AES128;
    endcase
  endfunction

  function automatic int unsigned nk_of(key_size_e ks);
    case (ks)
      AES192:  return 6;
      AES256:  return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned nr_of(key_size_e ks);
    return nk_of(ks) + 6;
  endfunction

  function automatic int unsigned nw_of(key_size_e ks);
    return 4 * (nr_of(ks) + 1);
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational S-box substitution of one 32-bit schedule word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] result
);

  assign result = sub_word(word);

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion: one schedule word per clock into a round-key buffer,
// with a registered round-key read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                done,
  input  logic                rd_en,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key,
  output logic                rd_valid
);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  localparam key_size_e   KeySize = key_size_of(KEY_BITS);
  localparam int unsigned NK      = nk_of(KeySize);
  localparam int unsigned NR      = nr_of(KeySize);
  localparam int unsigned NW      = nw_of(KeySize);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e         state_q;
  logic [31:0]    w_q [NW];
  logic [5:0]     i_q;
  logic [2:0]     mod_q;
  logic [7:0]     rcon_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_valid_q;
  logic [127:0]   rd_key_q;

  logic           accept;
  logic           rd_hit;
  logic [5:0]     rd_base;
  logic [31:0]    prev_w;
  logic [31:0]    back_w;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    temp_w;
  logic [31:0]    next_w;

  assign key_ready = ~busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_key    = rd_key_q;

  assign accept  = key_valid && !busy_q;
  assign rd_base = {rd_round, 2'b00};
  // A read racing a new key would see a buffer about to be overwritten, so it is refused.
  assign rd_hit  = rd_en && done_q && !accept && (32'(rd_round) <= NR);

  assign prev_w = w_q[i_q - 6'd1];
  assign back_w = w_q[i_q - 6'(NK)];

  always_comb begin
    sub_in = prev_w;
    if (mod_q == '0) begin
      sub_in = rot_word(prev_w);
    end
  end

  aes_subword u_subword (
    .word   (sub_in),
    .result (sub_out)
  );

  always_comb begin
    temp_w = prev_w;
    if (mod_q == '0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && mod_q == 3'd4) begin
      temp_w = sub_out;
    end
    next_w = back_w ^ temp_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      i_q        <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_key_q   <= rd_hit ? {w_q[rd_base], w_q[rd_base + 6'd1],
                              w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]} : '0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            for (int unsigned k = 0; k < NK; k++) begin
              w_q[k] <= key[KEY_BITS-1-32*k -: 32];
            end
            i_q     <= 6'(NK);
            mod_q   <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StExpand;
          end
        end
        StExpand: begin
          // One idle step after the last word keeps done aligned with a fully written buffer.
          if (i_q == 6'(NW)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            w_q[i_q] <= next_w;
            i_q      <= i_q + 6'd1;
            mod_q    <= (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
            if (mod_q == '0) begin
              rcon_q <= xtime(rcon_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: 128/192/256-bit instances driven together, scoreboarded reads.
module tb_aes_key_schedule;
  import aes_pkg::*;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] key128 = K128;
  logic [191:0] key192 = K192;
  logic [255:0] key256 = K256;

  logic         ready_a [3];
  logic         busy_a [3];
  logic         done_a [3];
  logic         rd_valid_a [3];
  logic [127:0] rd_key_a [3];

  always #5 clk = ~clk;

  aes_key_schedule #(.KEY_BITS(128)) dut128 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(ready_a[0]), .key(key128),
    .busy(busy_a[0]), .done(done_a[0]), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rd_key_a[0]), .rd_valid(rd_valid_a[0])
  );
  aes_key_schedule #(.KEY_BITS(192)) dut192 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(ready_a[1]), .key(key192),
    .busy(busy_a[1]), .done(done_a[1]), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rd_key_a[1]), .rd_valid(rd_valid_a[1])
  );
  aes_key_schedule #(.KEY_BITS(256)) dut256 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(ready_a[2]), .key(key256),
    .busy(busy_a[2]), .done(done_a[2]), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rd_key_a[2]), .rd_valid(rd_valid_a[2])
  );

  typedef struct {
    int           due;
    int           d;
    logic         ev;
    logic [127:0] ek;
    string        name;
  } sb_entry_t;

  typedef struct {
    int           d;
    logic [3:0]   r;
    logic         ev;
    logic [127:0] ek;
  } vec_t;

  sb_entry_t    sb [$];
  logic [127:0] rk [3][16];
  int           lat [3] = '{41, 47, 53};
  int           nr [3] = '{10, 12, 14};
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;
  bit           loaded = 1'b0;
  int           load_edge = 0;

  task automatic check(input string nm, input bit ok, input logic [128:0] got,
                       input logic [128:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic logic [31:0] tb_sub(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Straight FIPS-197 expansion; key left-aligned in 256 bits.
  function automatic logic [127:0] model_rk(input logic [255:0] k, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = tb_sub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk == 8 && i % nk == 4) begin
        t = tb_sub(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic bit exp_done(input int d, input int c);
    return loaded && (c >= load_edge + lat[d]);
  endfunction

  function automatic bit exp_busy(input int d, input int c);
    return loaded && (c >= load_edge) && (c < load_edge + lat[d]);
  endfunction

  task automatic push(input int d, input logic ev, input logic [127:0] ek, input string nm);
    sb_entry_t e;
    e.due = cyc + 1;
    e.d = d;
    e.ev = ev;
    e.ek = ek;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Drives one cycle of stimulus from a negedge and queues model expectations for masked DUTs.
  task automatic apply(input bit kv, input bit en, input logic [3:0] r, input bit [2:0] mask,
                       input string nm);
    bit acc;
    bit ev;
    key_valid = kv;
    rd_en = en;
    rd_round = r;
    acc = kv && !exp_busy(0, cyc);
    for (int d = 0; d < 3; d++) begin
      if (mask[d]) begin
        ev = en && exp_done(d, cyc) && (int'(r) <= nr[d]) && !acc;
        push(d, ev, ev ? rk[d][r] : 128'h0, nm);
      end
    end
    if (acc) begin
      loaded = 1'b1;
      load_edge = cyc + 1;
    end
    @(negedge clk);
    key_valid = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wait_done(input bit inject);
    int meas [3];
    int start;
    meas = '{-1, -1, -1};
    start = load_edge;
    for (int k = 1; k <= 70; k++) begin
      if (inject && k == 10) begin
        key128 = ~K128;
        key192 = ~K192;
        key256 = ~K256;
      end
      apply(inject && k == 10, 1'b1, 4'd1, 3'b111, "rd_during_expand");
      key128 = K128;
      key192 = K192;
      key256 = K256;
      for (int d = 0; d < 3; d++) begin
        if (meas[d] < 0 && done_a[d] === 1'b1) meas[d] = cyc - start;
      end
      if (meas[0] >= 0 && meas[1] >= 0 && meas[2] >= 0) break;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("latency_dut%0d", d), meas[d] == lat[d], 129'(meas[d]), 129'(lat[d]));
    end
  endtask

  task automatic check_idle(input string nm);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_status_dut%0d", nm, d),
            {busy_a[d], done_a[d], ready_a[d], rd_valid_a[d]} === 4'b0010,
            129'({busy_a[d], done_a[d], ready_a[d], rd_valid_a[d]}), 129'(4'b0010));
      check($sformatf("%s_rdkey_dut%0d", nm, d), rd_key_a[d] === 128'h0,
            129'(rd_key_a[d]), 129'h0);
    end
  endtask

  // Scoreboard: compares each queued read expectation one time unit after its sampling edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check(e.name, (rd_valid_a[e.d] === e.ev) && (rd_key_a[e.d] === e.ek),
              {rd_valid_a[e.d], rd_key_a[e.d]}, {e.ev, e.ek});
      end
    end
  end

  initial begin
    vec_t vt [11];
    int   pulses [3];

    rk[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
              128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
              128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
              128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
              128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0};
    for (int r = 0; r < 16; r++) begin
      rk[1][r] = (r <= 12) ? model_rk({K192, 64'h0}, 6, r) : 128'h0;
      rk[2][r] = (r <= 14) ? model_rk(K256, 8, r) : 128'h0;
    end

    vt[0]  = '{0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[1]  = '{0, 4'd2,  1'b1, 128'hf2c295f27a96b9435935807a7359f67f};
    vt[2]  = '{0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3]  = '{1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
    vt[4]  = '{2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e};
    vt[5]  = '{0, 4'd0,  1'b1, K128};
    vt[6]  = '{1, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5};
    vt[7]  = '{2, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
    vt[8]  = '{0, 4'd11, 1'b0, 128'h0};
    vt[9]  = '{1, 4'd13, 1'b0, 128'h0};
    vt[10] = '{2, 4'd15, 1'b0, 128'h0};

    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    loaded = 1'b0;

    // Load all three keys together; a different key at cycle 10 must be ignored.
    apply(1'b1, 1'b0, 4'd0, 3'b000, "load");
    wait_done(1'b1);

    pulses = '{0, 0, 0};
    for (int r = 0; r <= 10; r++) begin
      apply(1'b0, 1'b1, 4'(r), 3'b111, "b2b_read");
      for (int d = 0; d < 3; d++) pulses[d] += int'(rd_valid_a[d]);
    end
    apply(1'b0, 1'b0, 4'd0, 3'b111, "b2b_idle");
    for (int d = 0; d < 3; d++) begin
      pulses[d] += int'(rd_valid_a[d]);
      check($sformatf("b2b_pulses_dut%0d", d), pulses[d] == 11, 129'(pulses[d]), 129'd11);
    end
    for (int r = 11; r <= 15; r++) apply(1'b0, 1'b1, 4'(r), 3'b111, "high_round_read");

    for (int i = 0; i < 11; i++) begin
      rd_en = 1'b1;
      rd_round = vt[i].r;
      push(vt[i].d, vt[i].ev, vt[i].ek, $sformatf("vector%0d", i));
      @(negedge clk);
      rd_en = 1'b0;
    end

    // Read on the acceptance cycle, then abort expansion with reset and reload.
    apply(1'b1, 1'b1, 4'd1, 3'b111, "rd_on_accept");
    for (int k = 1; k < 20; k++) apply(1'b0, 1'b0, 4'd0, 3'b000, "");
    reset = 1'b1;
    key_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key_valid = 1'b0;
    loaded = 1'b0;
    check_idle("mid_reset");
    apply(1'b0, 1'b1, 4'd1, 3'b111, "rd_after_reset");
    apply(1'b1, 1'b0, 4'd0, 3'b000, "reload");
    wait_done(1'b0);
    apply(1'b0, 1'b1, 4'd1, 3'b111, "rd_after_reload");
    apply(1'b0, 1'b1, 4'd10, 3'b111, "rd_after_reload");

    repeat (3) @(negedge clk);
    check("sb_drain", sb.size() == 0, 129'(sb.size()), 129'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
